// File: rtl/rr_arb2_stage.sv
// Two-input round-robin stream arbiter with a single-entry registered output.
// Drives the external 2:1 mux select and captures the mux result on transfer.
module rr_arb2_stage #(
  parameter int unsigned N = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [N-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [N-1:0] b_data,
  output logic         b_ready,
  output logic         sel,
  input  logic [N-1:0] mux_y,
  output logic         y_valid,
  output logic [N-1:0] y_data,
  output logic         y_src,
  input  logic         y_ready
);

  logic         last_grant_q, last_grant_d;
  logic         y_valid_q, y_valid_d;
  logic [N-1:0] y_data_q, y_data_d;
  logic         y_src_q, y_src_d;

  logic can_accept_c;
  logic grant_c;
  logic xfer_c;

  // The output slot can refill in the same cycle it drains, so there is no bubble.
  assign can_accept_c = ~y_valid_q | y_ready;

  // A lone requester always wins; under contention or idle the pointer decides.
  always_comb begin
    grant_c = ~last_grant_q;
    if (a_valid && !b_valid) begin
      grant_c = 1'b0;
    end else if (!a_valid && b_valid) begin
      grant_c = 1'b1;
    end
  end

  assign sel     = grant_c;
  assign a_ready = can_accept_c & ~grant_c;
  assign b_ready = can_accept_c & grant_c;
  assign xfer_c  = (a_valid & a_ready) | (b_valid & b_ready);

  // The pointer moves only on a real transfer, so idle cycles never skew fairness.
  always_comb begin
    last_grant_d = last_grant_q;
    y_valid_d    = y_valid_q;
    y_data_d     = y_data_q;
    y_src_d      = y_src_q;
    if (xfer_c) begin
      y_valid_d    = 1'b1;
      y_data_d     = mux_y;
      y_src_d      = grant_c;
      last_grant_d = grant_c;
    end else if (y_valid_q && y_ready) begin
      y_valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      y_valid_q    <= 1'b0;
      y_data_q     <= '0;
      y_src_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      y_valid_q    <= y_valid_d;
      y_data_q     <= y_data_d;
      y_src_q      <= y_src_d;
    end
  end

  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_src   = y_src_q;

endmodule

// File: tb/tb_rr_arb2_stage.sv
// Directed bench for rr_arb2_stage: stimulus pushes hand-computed expected words,
// a negedge monitor pops and compares every word the consumer accepts.
module tb_rr_arb2_stage;

  localparam int unsigned N = 128;

  typedef struct packed {
    logic [N-1:0] data;
    logic         src;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         a_valid;
  logic [N-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [N-1:0] b_data;
  logic         b_ready;
  logic         sel;
  logic [N-1:0] mux_y;
  logic         y_valid;
  logic [N-1:0] y_data;
  logic         y_src;
  logic         y_ready;

  int   n_checks;
  int   n_fails;
  exp_t exp_q[$];

  rr_arb2_stage #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .sel     (sel),
    .mux_y   (mux_y),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_src   (y_src),
    .y_ready (y_ready)
  );

  // External 2:1 mux the arbiter steers
  assign mux_y = sel ? b_data : a_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_word(input logic [N-1:0] d, input logic s);
    exp_t e;
    e.data = d;
    e.src  = s;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic av, input logic [N-1:0] ad,
                       input logic bv, input logic [N-1:0] bd, input logic yr);
    a_valid = av;
    a_data  = ad;
    b_valid = bv;
    b_data  = bd;
    y_ready = yr;
  endtask

  task automatic check_grant(input string name, input logic exp_sel, input logic exp_can);
    check1({name, "_sel"}, sel, exp_sel);
    check1({name, "_a_ready"}, a_ready, exp_can & ~exp_sel);
    check1({name, "_b_ready"}, b_ready, exp_can & exp_sel);
  endtask

  task automatic to_next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every word the consumer takes must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && y_valid && y_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_output: got data %0h src %0b, none expected", y_data, y_src);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkw("y_data", y_data, e.data);
        check1("y_src", y_src, e.src);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state; idle grant follows ~last_grant = A
    @(negedge clk);
    check1("rst_y_valid", y_valid, 1'b0);
    checkw("rst_y_data", y_data, '0);
    check1("rst_y_src", y_src, 1'b0);
    check_grant("rst_idle", 1'b0, 1'b1);
    to_next_cycle();

    // Single source A, full throughput
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, N'(8'h11 + i), 1'b0, N'(8'hEE), 1'b1);
      expect_word(N'(8'h11 + i), 1'b0);
      @(negedge clk);
      check_grant("single", 1'b0, 1'b1);
      to_next_cycle();
    end

    // Drain without refill: 0x14 leaves, data register holds its value
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    @(negedge clk);
    to_next_cycle();
    @(negedge clk);
    check1("drain_y_valid", y_valid, 1'b0);
    checkw("drain_y_data", y_data, N'(8'h14));
    to_next_cycle();

    // Load a word that the mid-stream reset will drop
    drive(1'b1, N'(8'h55), 1'b0, '0, 1'b0);
    @(negedge clk);
    check_grant("preload", 1'b0, 1'b1);
    to_next_cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check1("held_y_valid", y_valid, 1'b1);
    checkw("held_y_data", y_data, N'(8'h55));
    #2;
    rst = 1'b1;
    #1;
    check1("async_rst_y_valid", y_valid, 1'b0);
    checkw("async_rst_y_data", y_data, '0);
    check1("async_rst_y_src", y_src, 1'b0);
    to_next_cycle();
    rst = 1'b0;

    // Continuous contention: A0,B0,A1,B1 with producers holding until accepted
    begin
      int ai;
      int bi;
      ai = 0;
      bi = 0;
      for (int i = 0; i < 4; i++) begin
        logic exp_sel;
        exp_sel = 1'((i % 2) != 0);
        drive(1'b1, N'(8'hA0 + ai), 1'b1, N'(8'hB0 + bi), 1'b1);
        if (exp_sel) begin
          expect_word(N'(8'hB0 + bi), 1'b1);
          bi++;
        end else begin
          expect_word(N'(8'hA0 + ai), 1'b0);
          ai++;
        end
        @(negedge clk);
        check_grant("contend", exp_sel, 1'b1);
        to_next_cycle();
      end
    end

    // Backpressure: A2 held three cycles, then drains while B2 is taken
    drive(1'b1, N'(8'hA2), 1'b1, N'(8'hB2), 1'b1);
    expect_word(N'(8'hA2), 1'b0);
    @(negedge clk);
    check_grant("bp_load", 1'b0, 1'b1);
    to_next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, N'(8'h99 + i), 1'b1, N'(8'hB2), 1'b0);
      @(negedge clk);
      check1("bp_a_ready", a_ready, 1'b0);
      check1("bp_b_ready", b_ready, 1'b0);
      check1("bp_y_valid", y_valid, 1'b1);
      checkw("bp_y_data", y_data, N'(8'hA2));
      to_next_cycle();
    end
    drive(1'b0, '0, 1'b1, N'(8'hB2), 1'b1);
    expect_word(N'(8'hB2), 1'b1);
    @(negedge clk);
    check_grant("bp_release", 1'b1, 1'b1);
    to_next_cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    @(negedge clk);
    check1("no_bubble_y_valid", y_valid, 1'b1);
    checkw("no_bubble_y_data", y_data, N'(8'hB2));
    to_next_cycle();

    // Pointer hold: A wins, idle cycles leave the pointer alone, B wins next contention
    drive(1'b1, N'(8'h61), 1'b0, '0, 1'b1);
    expect_word(N'(8'h61), 1'b0);
    @(negedge clk);
    check_grant("ptr_a_wins", 1'b0, 1'b1);
    to_next_cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 1'b0, '0, 1'b1);
      @(negedge clk);
      check1("ptr_idle_sel", sel, 1'b1);
      to_next_cycle();
    end
    drive(1'b1, N'(8'h62), 1'b1, N'(8'h63), 1'b1);
    expect_word(N'(8'h63), 1'b1);
    @(negedge clk);
    check_grant("ptr_contend", 1'b1, 1'b1);
    to_next_cycle();
    drive(1'b1, N'(8'h62), 1'b0, '0, 1'b1);
    expect_word(N'(8'h62), 1'b0);
    @(negedge clk);
    check_grant("ptr_lone_a", 1'b0, 1'b1);
    to_next_cycle();

    drive(1'b0, '0, 1'b0, '0, 1'b1);
    repeat (3) to_next_cycle();
    check1("scoreboard_empty", 1'(exp_q.size() == 0), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rr_arb2_stage.md
Name: rr_arb2_stage

Overview:
- Two-input round-robin stream arbiter with a registered output stage.
- Sits directly upstream of the 2:1 data mux: generates the mux select and consumes the mux result into a single-entry output register.
- Each side uses a valid/ready handshake.
- Merges two N-bit producer streams into one consumer stream with fair alternation under contention and full one-transfer-per-cycle throughput.

Parameters:
- N, 128, data width of both input streams and the output stream.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  stream A has a word.
- a_data  input  N  stream A word.
- a_ready  output  1  stream A word accepted this cycle when a_valid & a_ready.
- b_valid  input  1  stream B has a word.
- b_data  input  N  stream B word.
- b_ready  output  1  stream B word accepted this cycle when b_valid & b_ready.
- sel  output  1  combinational grant to the 2:1 mux; 0 = A, 1 = B.
- mux_y  input  N  result of the 2:1 mux (sel ? b_data : a_data), captured into the output register.
- y_valid  output  1  output register holds a word.
- y_data  output  N  registered output word.
- y_src  output  1  source of y_data; 0 = A, 1 = B.
- y_ready  input  1  consumer accepts y_data when y_valid & y_ready.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - y_valid=0, y_data=0, y_src=0.
  - last_grant=1, so A wins the first contention.
- State:
  - last_grant (1 bit).
  - Output register: y_valid, y_data, y_src.
- Accept capability:
  - can_accept = ~y_valid | y_ready.
  - The stage takes a new word in the same cycle the old one drains (no bubble).
- Grant, combinational:
  - Only a_valid: sel=0.
  - Only b_valid: sel=1.
  - Both valid: sel = ~last_grant.
  - Neither valid: sel = ~last_grant (don't-care for data, but defined so sel never floats).
- Readies:
  - a_ready = can_accept & ~sel.
  - b_ready = can_accept & sel.
  - Readies never both high.
  - a_ready/b_ready may depend on both valids; no combinational path from y_data.
- Transfer (xfer):
  - xfer = (a_valid & a_ready) | (b_valid & b_ready).
  - On xfer: y_data <= mux_y, y_src <= sel, y_valid <= 1, last_grant <= sel.
  - No xfer and y_ready & y_valid: y_valid <= 0; y_data and y_src hold last value.
  - Otherwise all state holds.
- Latency and throughput:
  - Accepted word appears on y_data the cycle after acceptance.
  - Sustained throughput is 1 word/cycle with y_ready tied high.
- Fairness:
  - last_grant updates only on an actual transfer.
  - Under continuous contention the grant alternates A,B,A,B.
  - A lone requester is never blocked by the pointer.
- Backpressure:
  - y_valid=1 & y_ready=0: both readies 0.
  - y_data/y_src stable until accepted.
  - Producer inputs may change freely while not ready.
- Stability rule: producers hold valid/data until accepted; the block does not depend on it but verification checks it.
- Reset mid-operation: any held word is dropped (y_valid=0) and the pointer returns to 1 immediately, without waiting for a clock edge.
- Release: rst deasserted synchronously to clk by the reset synchroniser upstream.

Test Plan:
- Reset: assert rst mid-stream with y_valid=1 -> y_valid=0, y_data=0, y_src=0 immediately; first post-reset contention grants A (sel=0).
- Single source: a_valid=1 only, a_data=0x11..0x14 on consecutive cycles, y_ready=1 -> a_ready=1 every cycle, y_data=0x11..0x14 one cycle later, y_src=0, b_ready=0.
- Contention: both valid continuously (A words 0xA0.., B words 0xB0..), y_ready=1 -> y_data sequence 0xA0,0xB0,0xA1,0xB1, y_src 0,1,0,1, one word per cycle.
- Backpressure: y_valid=1 holding 0xA0, y_ready=0 for 3 cycles -> y_data stays 0xA0, a_ready=b_ready=0; on y_ready=1 with B pending, 0xA0 drains and B is accepted the same cycle (no bubble).
- Pointer hold: A wins, then 5 idle cycles, then both valid -> B granted (pointer unchanged by idle cycles).
- Drain without refill: y_valid=1, y_ready=1, no inputs valid -> y_valid=0 next cycle, y_data unchanged.
